display_mux: RTL



---
 rtl/display_mux_if.sv | 31 +++
 rtl/display_mux.sv | 136 +++++++++++++
 2 files changed

// File: rtl/display_mux_if.sv
// Bundle of the display driver's control and display-bus signals.
// Latency: n/a (wiring only).
// Backpressure: none; writes and shifts are accepted every cycle.
//
// Ports (signals):
//   clr, shift_en, wr_en, wr_addr, wr_code, wr_tipo : control side -> driver
//   seg (active-low a..g), an (active-low one-hot)  : driver -> board
// Modports: master = keypad/ALU control side, slave = display_mux.
interface display_mux_if #(
    parameter int NDIG = 4,
    parameter int AW   = (NDIG > 1) ? $clog2(NDIG) : 1
);
    logic            clr;
    logic            shift_en;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [3:0]      wr_code;
    logic            wr_tipo;
    logic [6:0]      seg;
    logic [NDIG-1:0] an;

    modport master (
        output clr, shift_en, wr_en, wr_addr, wr_code, wr_tipo,
        input  seg, an
    );

    modport slave (
        input  clr, shift_en, wr_en, wr_addr, wr_code, wr_tipo,
        output seg, an
    );
endinterface

// File: rtl/display_mux.sv
// Time-multiplexed seven-segment driver: NDIG {tipo,code} entries scanned onto one segment bus.
// Latency: a write/shift lands in storage at the sampling edge and on seg one edge later.
// Backpressure: none; clr > shift_en > wr_en resolved each cycle, all accepted immediately.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (display goes dark)
//   bus    : display_mux_if.slave (clr, shift_en, wr_en, wr_addr, wr_code, wr_tipo in;
//            seg active-low bit6=a..bit0=g, an active-low one-hot, bit i = digit i)
// Optional feature: define DISP_LZB_EN for leading-zero blanking.
module display_mux #(
    parameter int NDIG = 4,
    parameter int DIV  = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    display_mux_if.slave  bus
);
    localparam int AW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [4:0] ENT_BLANK = 5'h0F;  // tipo=0, code=F
    localparam logic [4:0] ENT_ZERO  = 5'h10;  // tipo=1, code=0

    logic [4:0]      r_dig [NDIG];
    logic [PW-1:0]   r_presc;
    logic [IW-1:0]   r_idx;
    logic [6:0]      r_seg;
    logic [NDIG-1:0] r_an;

    logic            w_tc;
    logic [4:0]      w_ent;
    logic            w_sel_blank;
    logic [6:0]      w_seg_next;

    function automatic logic [6:0] glyph_hex(input logic [3:0] c);
        case (c)
            4'h0: glyph_hex = 7'b0000001;
            4'h1: glyph_hex = 7'b1001111;
            4'h2: glyph_hex = 7'b0010010;
            4'h3: glyph_hex = 7'b0000110;
            4'h4: glyph_hex = 7'b1001100;
            4'h5: glyph_hex = 7'b0100100;
            4'h6: glyph_hex = 7'b0100000;
            4'h7: glyph_hex = 7'b0001111;
            4'h8: glyph_hex = 7'b0000000;
            4'h9: glyph_hex = 7'b0000100;
            4'hA: glyph_hex = 7'b0001000;
            4'hB: glyph_hex = 7'b1100000;
            4'hC: glyph_hex = 7'b0110001;
            4'hD: glyph_hex = 7'b1000010;
            4'hE: glyph_hex = 7'b0110000;
            default: glyph_hex = 7'b0111000;
        endcase
    endfunction

    function automatic logic [6:0] glyph_sym(input logic [3:0] c);
        case (c)
            4'h0: glyph_sym = 7'b1101100;  // +
            4'h1: glyph_sym = 7'b1111110;  // -
            4'h2: glyph_sym = 7'b1001000;  // *
            4'h3: glyph_sym = 7'b1011011;  // /
            4'h4: glyph_sym = 7'b0000001;  // o
            4'h5: glyph_sym = 7'b1101000;  // h
            default: glyph_sym = 7'b1111111;
        endcase
    endfunction

    // Digit storage. Shift has priority over a direct write in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) r_dig[i] <= ENT_BLANK;
        end else if (bus.clr) begin
            for (int i = 0; i < NDIG; i++) r_dig[i] <= ENT_BLANK;
        end else if (bus.shift_en) begin
            for (int i = NDIG - 1; i > 0; i--) r_dig[i] <= r_dig[i-1];
            r_dig[0] <= {bus.wr_tipo, bus.wr_code};
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(NDIG))) begin
            r_dig[bus.wr_addr] <= {bus.wr_tipo, bus.wr_code};
        end
    end

    // Prescaler and scan index run independently of any storage update.
    assign w_tc = (r_presc == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

`ifdef DISP_LZB_EN
    // Walk from the top digit down: blanking stays armed while every digit
    // seen so far is numeric zero or an empty entry. Digit 0 always shows.
    logic            w_lead;
    logic [NDIG-1:0] w_blank;

    always_comb begin
        w_blank = '0;
        w_lead  = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if ((i != 0) && w_lead && (r_dig[i] == ENT_ZERO)) w_blank[i] = 1'b1;
            w_lead = w_lead && ((r_dig[i] == ENT_ZERO) || (r_dig[i] == ENT_BLANK));
        end
    end

    assign w_sel_blank = w_blank[r_idx];
`else
    assign w_sel_blank = 1'b0;
`endif

    assign w_ent      = r_dig[r_idx];
    assign w_seg_next = w_sel_blank ? 7'b1111111 :
                        (w_ent[4] ? glyph_hex(w_ent[3:0]) : glyph_sym(w_ent[3:0]));

    // seg and an load on the same edge from the same index, so the pair is always coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'b1111111;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= ~(NDIG'(1) << r_idx);
        end
    end

    assign bus.seg = r_seg;
    assign bus.an  = r_an;
endmodule
